// File: rtl/data_ram_responder.sv
// Data-memory responder: latched word request, optional wait states, byte-masked write or full-word read.
// State | meaning: IDLE wait for req_i | WAIT count wait states | ACCESS range check + RAM op | RESP ready_o pulse
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  byte_enable_i,
  input  logic [31:0] write_data_i,
  output logic        ready_o,
  output logic [31:0] read_data_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic [31:2] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [0:(1 << ADDR_WIDTH)-1];

  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic                  w_oor;
  logic                  w_unused;

  assign w_word_addr = r_addr[ADDR_WIDTH+1:2];
  assign w_oor       = |r_addr[31:ADDR_WIDTH+2];
  assign w_unused    = ^addr_i[1:0];
  assign ready_o     = (r_state == S_RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_i) begin
        r_we    <= we_i;
        r_addr  <= addr_i[31:2];
        r_be    <= byte_enable_i;
        r_wdata <= write_data_i;
        r_cnt   <= WS;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_i) w_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_cnt <= 3'd1) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Response registers hold between transactions; only ACCESS updates them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_data_o <= 32'd0;
      fault_o     <= 1'b0;
    end else if (r_state == S_ACCESS) begin
      if (w_oor) begin
        read_data_o <= 32'd0;
        fault_o     <= 1'b1;
      end else begin
        fault_o <= 1'b0;
        if (!r_we) read_data_o <= r_mem[w_word_addr];
      end
    end
  end

  // RAM array has no reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (r_state == S_ACCESS && r_we && !w_oor) begin
      for (int n = 0; n < 4; n++) begin
        if (r_be[n]) r_mem[w_word_addr][8*n +: 8] <= r_wdata[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: one instance with one wait state, one with none, sharing all inputs.
module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ra, fa, rb, fb;
  logic [31:0] rda, rdb;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_f;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .byte_enable_i(be), .write_data_i(wdata),
    .ready_o(ra), .read_data_o(rda), .fault_o(fa)
  );

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .byte_enable_i(be), .write_data_i(wdata),
    .ready_o(rb), .read_data_o(rdb), .fault_o(fb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Entered just after a rising edge; scrambles inputs after acceptance.
  task automatic run_txn(input int idx, input vec_t v);
    int lat_a, lat_b, na, nb;
    logic [31:0] cap_rda, cap_rdb;
    logic cap_fa, cap_fb;
    lat_a = 0; lat_b = 0; na = 0; nb = 0;
    cap_rda = 'x; cap_rdb = 'x; cap_fa = 1'bx; cap_fb = 1'bx;
    req = 1'b1; we = v.we; addr = v.addr; be = v.be; wdata = v.wdata;
    @(posedge clk); #1;
    req = 1'b0; we = ~v.we; addr = $urandom; be = 4'($urandom); wdata = $urandom;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ra) begin
        na++;
        if (lat_a == 0) begin lat_a = k; cap_rda = rda; cap_fa = fa; end
      end
      if (rb) begin
        nb++;
        if (lat_b == 0) begin lat_b = k; cap_rdb = rdb; cap_fb = fb; end
      end
    end
    chk($sformatf("v%0d_lat_a", idx), 32'(lat_a), 32'd2);
    chk($sformatf("v%0d_pulses_a", idx), 32'(na), 32'd1);
    chk($sformatf("v%0d_rdata_a", idx), cap_rda, v.exp_rd);
    chk($sformatf("v%0d_fault_a", idx), {31'd0, cap_fa}, {31'd0, v.exp_f});
    chk($sformatf("v%0d_lat_b", idx), 32'(lat_b), 32'd1);
    chk($sformatf("v%0d_pulses_b", idx), 32'(nb), 32'd1);
    chk($sformatf("v%0d_rdata_b", idx), cap_rdb, v.exp_rd);
    chk($sformatf("v%0d_fault_b", idx), {31'd0, cap_fb}, {31'd0, v.exp_f});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2, nb;
    logic [31:0] d1, d2;
    vec_t rv;

    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 4'h4, 32'h00AB_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         32'h11AB_3344, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0020, 4'h3, 32'h0000_CDEF, 32'h11AB_3344, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h11AB_CDEF, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, 32'h11AB_CDEF, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h11AB_CDEF, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 32'h11AB_CDEF, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0030, 4'hF, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};
    vecs[14] = '{1'b0, 32'h8000_0010, 4'hF, 32'h0,         32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, 32'h0000_0012, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_a", {ra, fa, rda[29:0]}, 32'd0);
      chk("idle_b", {rb, fb, rdb[29:0]}, 32'd0);
    end

    for (int i = 0; i < 16; i++) run_txn(i, vecs[i]);

    // Reset while the write to 0x30 is in flight (A in WAIT, B in ACCESS).
    req = 1'b1; we = 1'b1; addr = 32'h30; be = 4'hF; wdata = 32'h5555_5555;
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", {30'd0, ra, rb}, 32'd0);
    chk("rst_rdata_a", rda, 32'd0);
    chk("rst_rdata_b", rdb, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_ready", {30'd0, ra, rb}, 32'd0);
    rst_n = 1'b1;
    rv = '{1'b0, 32'h30, 4'hF, 32'h0, 32'h0, 1'b0};
    run_txn(16, rv);

    // Back-to-back reads with req_i held; B has no wait states.
    e1 = 0; e2 = 0; nb = 0; d1 = 'x; d2 = 'x;
    req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'h0;
    @(posedge clk); #1;
    addr = 32'h20;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (rb) begin
        nb++;
        if (nb == 1) begin e1 = k; d1 = rdb; end
        else if (nb == 2) begin e2 = k; d2 = rdb; end
      end
      if (k == 4) req = 1'b0;
    end
    chk("b2b_first_edge", 32'(e1), 32'd1);
    chk("b2b_second_edge", 32'(e2), 32'd4);
    chk("b2b_pulse_count", 32'(nb), 32'd2);
    chk("b2b_first_data", d1, 32'hDEAD_BEEF);
    chk("b2b_second_data", d2, 32'h11AB_CDEF);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Memory-side responder for the core's data-memory port.
- Accepts word-aligned requests carrying a 4-bit byte-enable strobe and lane-aligned write data, as produced by the core's load/store alignment logic.
- Performs byte-masked writes or full-word reads on an internal word-addressed RAM, with a configurable number of wait states.
- Returns the raw 32-bit word with a single-cycle ready pulse; sign/zero extension stays on the core side.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words (4 KiB by default).
- WAIT_STATES, 1, extra cycles inserted before the access; legal range 0..7.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  1  request valid; sampled only in IDLE.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  32  byte address; bits [1:0] ignored (alignment is the requester's job).
- byte_enable_i  input  4  write lane strobe; bit n enables byte lane n ([8n+7:8n]).
- write_data_i  input  32  lane-aligned write data.
- ready_o  output  1  one-cycle completion pulse.
- read_data_o  output  32  raw word for reads; valid while ready_o=1.
- fault_o  output  1  out-of-range address; qualified by ready_o.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State = IDLE; ready_o=0, read_data_o=0, fault_o=0, wait counter=0.
  - RAM contents are not reset.
  - Reset mid-transaction aborts it: a write not yet committed is never committed.
- Synchronous logic: all other logic is synchronous to the clk_i rising edge.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_i=1 at an edge latches we_i, addr_i, byte_enable_i and write_data_i.
  - Next state is WAIT (counter loaded with WAIT_STATES) or, if WAIT_STATES=0, ACCESS.
  - req_i=0: stay in IDLE.
- WAIT: counter decrements each edge; moves to ACCESS on the edge where counter=1. Exactly WAIT_STATES cycles are spent here.
- ACCESS, one cycle; at its closing edge:
  - Range check: out of range when latched addr[31:ADDR_WIDTH+2] != 0. Then the RAM is untouched, read_data_o<=0, fault_o<=1.
  - Write, in range: each RAM byte lane n with byte_enable[n]=1 takes write_data[8n+7:8n]; other lanes keep their value. read_data_o is unchanged. fault_o<=0.
  - Write with byte_enable=0000: no RAM change; completes normally.
  - Read, in range: read_data_o <= RAM[addr[ADDR_WIDTH+1:2]], full word with byte_enable ignored. fault_o<=0.
  - Next state RESP.
- RESP: ready_o=1 for exactly this one cycle; next state IDLE unconditionally.
- Latency: with acceptance at edge E0, ready_o is high in the cycle following edge E(WAIT_STATES+1). Default: third cycle after acceptance.
- ready_o is low in every state except RESP.
- Request inputs are latched, so changing or dropping req_i or the data inputs after acceptance has no effect on the transaction in flight.
- Back-to-back:
  - req_i still high at the RESP->IDLE edge is not consumed.
  - IDLE samples it one edge later, giving a gap of exactly one IDLE cycle between transactions.
  - A requester holding req_i continuously therefore issues repeated transactions. The requester must drop req_i in the ready_o cycle to avoid a duplicate.
- Output hold:
  - read_data_o holds its value until the next read or faulting ACCESS.
  - fault_o holds until the next ACCESS.
- RAM: single port, inferred as synchronous block RAM; no read-during-write hazard (one access per transaction).

Test Plan:
- Reset, then IDLE with req_i=0 for 10 cycles -> ready_o, fault_o stay 0; read_data_o=0.
- Full-word write then read (WAIT_STATES=1):
  - Write 0xDEADBEEF, be=1111, to 0x0000_0010; then read 0x0000_0010.
  - Required: each ready_o pulse lands exactly 3 cycles after acceptance; read returns 0xDEADBEEF, fault_o=0.
- Byte and half lanes:
  - Seed 0x0000_0020 with 0x11223344.
  - Write be=0100 with data 0x00AB0000, then read -> 0x11AB3344.
  - Write be=0011 with data 0x0000CDEF, then read -> 0x11ABCDEF.
  - Write be=0000 -> word unchanged.
- Out of range: write 0xFFFFFFFF, be=1111, to 0x0000_1000; read 0x0000_1000.
  - Both complete with ready_o=1, fault_o=1, read_data_o=0.
  - A subsequent read of 0x0000_0000 is unchanged.
- Back-to-back with WAIT_STATES=0: hold req_i high across two reads (0x10, 0x20).
  - ready_o pulses are 3 cycles apart.
  - Dropping req_i in the second ready_o cycle leaves no third transaction.
- Reset mid-write: assert rst_ni=0 while in WAIT during a write of 0x55555555 to 0x30 (previously 0).
  - Required: ready_o=0 immediately; after reset, a read of 0x30 returns 0.
